// File: rtl/rps_pkg.sv
// Shared codes for the rock-paper-scissors match driver: moves, judge verdicts,
// judge FSM states, driver FSM states and the LFSR constants.
package rps_pkg;

  localparam logic [1:0] MOVE_STONE    = 2'b00;
  localparam logic [1:0] MOVE_PAPER    = 2'b01;
  localparam logic [1:0] MOVE_SCISSORS = 2'b10;
  localparam logic [1:0] MOVE_ILLEGAL  = 2'b11;

  localparam logic [1:0] VERDICT_TIE     = 2'b00;
  localparam logic [1:0] VERDICT_P1      = 2'b01;
  localparam logic [1:0] VERDICT_P2      = 2'b10;
  localparam logic [1:0] VERDICT_INVALID = 2'b11;

  localparam logic [2:0] JUDGE_IDLE     = 3'b000;
  localparam logic [2:0] JUDGE_EVALUATE = 3'b001;
  localparam logic [2:0] JUDGE_RESULT   = 3'b010;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // The illegal code is never offered by the computer player
  function automatic logic [1:0] comp_move(input logic [1:0] bits);
    return (bits == MOVE_ILLEGAL) ? MOVE_STONE : bits;
  endfunction

endpackage

// File: rtl/rps_lfsr.sv
// 8-bit Galois LFSR used as the computer player's move source.
module rps_lfsr
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [1:0] move_bits
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= seed;
    else       lfsr_q <= lfsr_d;
  end

  assign move_bits = lfsr_q[1:0];

endmodule

// File: rtl/rps_match_driver.sv
// Match driver: issues rounds to an external judge FSM, tallies verdicts and
// declares a match winner once either side reaches WIN_TARGET round wins.
module rps_match_driver
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] p1_move,
  input  logic       play,
  input  logic       new_match,
  input  logic [2:0] judge_state,
  input  logic [1:0] judge_winner,
  output logic [1:0] p1_out,
  output logic [1:0] p2_out,
  output logic       start,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic [1:0] last_result,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       busy,
  output logic       reject,
  output logic       err_timeout,
  output logic       err_invalid,
  output logic [1:0] state_dbg
);

  // Handshake: start is held high from issue until the judge is seen in
  // EVALUATE (or the timeout fires); the next round may only be issued after
  // start has dropped and the judge has returned to IDLE.

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] TARGET  = 3'(WIN_TARGET);

  state_e     state_q, state_d;
  logic [1:0] p1_out_q, p1_out_d, p2_out_q, p2_out_d;
  logic       start_q, start_d, busy_q, busy_d, reject_q, reject_d;
  logic [2:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [1:0] last_result_q, last_result_d, match_winner_q, match_winner_d;
  logic       match_over_q, match_over_d;
  logic       err_timeout_q, err_timeout_d, err_invalid_q, err_invalid_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lfsr_bits;

  rps_lfsr u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .en        (1'b1),
    .seed      (LFSR_SEED),
    .move_bits (lfsr_bits)
  );

  always_comb begin
    state_d        = state_q;
    p1_out_d       = p1_out_q;
    p2_out_d       = p2_out_q;
    start_d        = start_q;
    reject_d       = 1'b0;
    score_p1_d     = score_p1_q;
    score_p2_d     = score_p2_q;
    last_result_d  = last_result_q;
    match_over_d   = match_over_q;
    match_winner_d = match_winner_q;
    err_timeout_d  = err_timeout_q;
    err_invalid_d  = err_invalid_q;
    cnt_d          = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (new_match) begin
          state_d        = ST_IDLE;
          score_p1_d     = 3'd0;
          score_p2_d     = 3'd0;
          last_result_d  = VERDICT_TIE;
          match_over_d   = 1'b0;
          match_winner_d = 2'b00;
          err_timeout_d  = 1'b0;
          err_invalid_d  = 1'b0;
        end else if (play) begin
          if (state_q == ST_DONE || p1_move == MOVE_ILLEGAL) begin
            reject_d = 1'b1;
          end else begin
            p1_out_d = p1_move;
            p2_out_d = comp_move(lfsr_bits);
            start_d  = 1'b1;
            cnt_d    = 8'd0;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (judge_state == JUDGE_EVALUATE) begin
          last_result_d = judge_winner;
          case (judge_winner)
            VERDICT_P1:      if (score_p1_q != 3'd7) score_p1_d = score_p1_q + 3'd1;
            VERDICT_P2:      if (score_p2_q != 3'd7) score_p2_d = score_p2_q + 3'd1;
            VERDICT_INVALID: err_invalid_d = 1'b1;
            default:         ;
          endcase
          start_d = 1'b0;
          state_d = ST_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          err_timeout_d = 1'b1;
          start_d       = 1'b0;
          state_d       = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (judge_state == JUDGE_IDLE) begin
          if (score_p1_q == TARGET || score_p2_q == TARGET) begin
            state_d        = ST_DONE;
            match_over_d   = 1'b1;
            match_winner_d = (score_p1_q > score_p2_q) ? VERDICT_P1 :
                             (score_p2_q > score_p1_q) ? VERDICT_P2 : 2'b00;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ISSUE) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      p1_out_q       <= 2'b00;
      p2_out_q       <= 2'b00;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      reject_q       <= 1'b0;
      score_p1_q     <= 3'd0;
      score_p2_q     <= 3'd0;
      last_result_q  <= 2'b00;
      match_over_q   <= 1'b0;
      match_winner_q <= 2'b00;
      err_timeout_q  <= 1'b0;
      err_invalid_q  <= 1'b0;
      cnt_q          <= 8'd0;
    end else begin
      state_q        <= state_d;
      p1_out_q       <= p1_out_d;
      p2_out_q       <= p2_out_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      reject_q       <= reject_d;
      score_p1_q     <= score_p1_d;
      score_p2_q     <= score_p2_d;
      last_result_q  <= last_result_d;
      match_over_q   <= match_over_d;
      match_winner_q <= match_winner_d;
      err_timeout_q  <= err_timeout_d;
      err_invalid_q  <= err_invalid_d;
      cnt_q          <= cnt_d;
    end
  end

  assign p1_out       = p1_out_q;
  assign p2_out       = p2_out_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign reject       = reject_q;
  assign score_p1     = score_p1_q;
  assign score_p2     = score_p2_q;
  assign last_result  = last_result_q;
  assign match_over   = match_over_q;
  assign match_winner = match_winner_q;
  assign err_timeout  = err_timeout_q;
  assign err_invalid  = err_invalid_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_rps_match_driver.sv
// Bench for rps_match_driver: registered judge model, LFSR reference model and
// a scoreboard that checks the full status vector at every round end or reject.
module tb_rps_match_driver;

  localparam int W = 22;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] p1_move = 2'b00;
  logic       play = 1'b0;
  logic       new_match = 1'b0;
  logic [2:0] judge_state;
  logic [1:0] judge_winner;
  logic [1:0] p1_out, p2_out, last_result, match_winner, state_dbg;
  logic       start, match_over, busy, reject, err_timeout, err_invalid;
  logic [2:0] score_p1, score_p2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  // expected status
  logic [1:0] e_state = 2'd0, e_p1 = 2'b00, e_p2 = 2'b00, e_last = 2'b00, e_win = 2'b00;
  logic [2:0] e_s1 = 3'd0, e_s2 = 3'd0;
  logic       e_over = 1'b0, e_et = 1'b0, e_ei = 1'b0;

  // judge model controls
  int         judge_mode = 0;  // 0 compliant, 1 never evaluates
  logic [1:0] jv = 2'b00;
  logic [7:0] lfsr_m;
  logic       busy_prev = 1'b0;

  rps_match_driver dut (
    .clk(clk), .reset(reset), .p1_move(p1_move), .play(play), .new_match(new_match),
    .judge_state(judge_state), .judge_winner(judge_winner),
    .p1_out(p1_out), .p2_out(p2_out), .start(start),
    .score_p1(score_p1), .score_p2(score_p2), .last_result(last_result),
    .match_over(match_over), .match_winner(match_winner), .busy(busy),
    .reject(reject), .err_timeout(err_timeout), .err_invalid(err_invalid),
    .state_dbg(state_dbg)
  );

  // clock / reset-synchronous models
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {1'b0, lfsr_m[7:1]} ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
  end

  always @(posedge clk) begin
    if (reset) judge_state <= 3'b000;
    else begin
      case (judge_state)
        3'b000:  if (start && judge_mode == 0) judge_state <= 3'b001;
        3'b001:  judge_state <= 3'b010;
        3'b010:  if (!start) judge_state <= 3'b000;
        default: judge_state <= 3'b000;
      endcase
    end
  end

  assign judge_winner = (judge_state == 3'b001) ? jv : 2'b00;

  function automatic logic [W-1:0] exp_vec(input logic kind);
    return {kind, e_state, 1'b0, 1'b0, e_p1, e_p2, e_s1, e_s2, e_last,
            e_over, e_win, e_et, e_ei};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    if (!reset && (reject || (busy_prev && !busy))) begin
      act = {reject, state_dbg, start, busy, p1_out, p2_out, score_p1, score_p2,
             last_result, match_over, match_winner, err_timeout, err_invalid};
      if (exp_q.size() == 0) begin
        check("unexpected_event", act, '0);
      end else begin
        exp = exp_q.pop_front();
        check("status_vec", act, exp);
      end
    end
    busy_prev = busy;
  end

  // driver tasks (all entered right after a negedge)
  task automatic do_round(input logic [1:0] mv, input logic [1:0] verdict,
                          input int mode, input int opt);
    int n;
    logic [2:0] old_s1;
    judge_mode = mode;
    jv         = verdict;
    e_p1       = mv;
    e_p2       = (lfsr_m[1:0] == 2'b11) ? 2'b00 : lfsr_m[1:0];
    old_s1     = e_s1;
    p1_move    = mv;
    play       = 1'b1;
    @(negedge clk);
    play = 1'b0;
    check("start_rise", start, 1);
    check("busy_rise", busy, 1);
    if (mode == 0) begin
      e_last = verdict;
      if (verdict == 2'b01 && e_s1 != 3'd7) e_s1 = e_s1 + 3'd1;
      if (verdict == 2'b10 && e_s2 != 3'd7) e_s2 = e_s2 + 3'd1;
      if (verdict == 2'b11) e_ei = 1'b1;
    end else begin
      e_et = 1'b1;
    end
    if (e_s1 == 3'd3 || e_s2 == 3'd3) begin
      e_state = 2'd3;
      e_over  = 1'b1;
      e_win   = (e_s1 > e_s2) ? 2'b01 : (e_s2 > e_s1) ? 2'b10 : 2'b00;
    end else begin
      e_state = 2'd0;
    end
    exp_q.push_back(exp_vec(1'b0));
    if (opt == 1) begin
      @(negedge clk);
      check("score_before_eval", score_p1, old_s1);
      check("start_held", start, 1);
      @(negedge clk);
      check("score_after_eval", score_p1, e_s1);
      check("start_fall", start, 0);
    end else if (opt == 2) begin
      new_match = 1'b1;
      @(negedge clk);
      new_match = 1'b0;
      check("new_match_ignored_busy", busy, 1);
    end else if (opt == 3) begin
      repeat (14) @(negedge clk);
      check("timeout_not_yet", err_timeout, 0);
      check("start_held_issue", start, 1);
      @(negedge clk);
      check("timeout_flag", err_timeout, 1);
      check("start_drop_timeout", start, 0);
    end
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("round_done", busy, 0);
    @(negedge clk);
  endtask

  task automatic do_reject(input logic [1:0] mv);
    p1_move = mv;
    play    = 1'b1;
    exp_q.push_back(exp_vec(1'b1));
    @(negedge clk);
    play = 1'b0;
    check("reject_pulse", reject, 1);
    check("reject_no_start", start, 0);
    @(negedge clk);
    check("reject_one_cycle", reject, 0);
    check("reject_state", state_dbg, e_state);
  endtask

  task automatic do_new_match(input logic with_play);
    new_match = 1'b1;
    play      = with_play;
    p1_move   = 2'b01;
    @(negedge clk);
    new_match = 1'b0;
    play      = 1'b0;
    e_state = 2'd0; e_s1 = 3'd0; e_s2 = 3'd0; e_last = 2'b00;
    e_over = 1'b0; e_win = 2'b00; e_et = 1'b0; e_ei = 1'b0;
    check("nm_clear", {state_dbg, score_p1, score_p2, last_result, match_over,
                       match_winner, err_timeout, err_invalid, start, busy},
          {e_state, e_s1, e_s2, e_last, e_over, e_win, e_et, e_ei, 1'b0, 1'b0});
    @(negedge clk);
    check("nm_play_dropped", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {reject, state_dbg, start, busy, p1_out, p2_out, score_p1,
                          score_p2, last_result, match_over, match_winner,
                          err_timeout, err_invalid}, exp_vec(1'b0));

    do_round(2'b00, 2'b01, 0, 1);   // P1 wins, latency checked
    do_reject(2'b11);               // illegal move
    do_round(2'b01, 2'b00, 0, 0);   // tie
    do_round(2'b10, 2'b11, 0, 0);   // invalid verdict
    do_new_match(1'b1);             // new_match beats play
    do_round(2'b10, 2'b00, 1, 3);   // judge silent -> timeout
    do_new_match(1'b0);
    do_round(2'b00, 2'b10, 0, 2);   // P2 wins, new_match mid-round ignored
    do_new_match(1'b0);
    do_round(2'b01, 2'b01, 0, 0);
    do_round(2'b10, 2'b01, 0, 0);
    do_round(2'b00, 2'b01, 0, 0);   // third win -> DONE
    check("match_over", match_over, 1);
    check("match_winner", match_winner, 2'b01);
    do_reject(2'b00);               // play refused in DONE
    check("done_scores", {score_p1, score_p2}, {3'd3, 3'd0});
    do_new_match(1'b0);

    // reset while in ISSUE
    do_round(2'b01, 2'b01, 0, 0);
    judge_mode = 1;
    p1_move    = 2'b10;
    play       = 1'b1;
    @(negedge clk);
    play = 1'b0;
    check("issue_before_reset", state_dbg, 2'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_start", start, 0);
    check("reset_mid_scores", {score_p1, score_p2}, 6'd0);
    check("reset_mid_state", state_dbg, 2'd0);
    reset = 1'b0;
    e_state = 2'd0; e_p1 = 2'b00; e_p2 = 2'b00; e_s1 = 3'd0; e_s2 = 3'd0;
    e_last = 2'b00; e_over = 1'b0; e_win = 2'b00; e_et = 1'b0; e_ei = 1'b0;
    @(negedge clk);
    do_round(2'b01, 2'b10, 0, 0);   // normal round after reset

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
